// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and defaults for the round-robin lock arbiter.
package rr_lock_arbiter_pkg;

    localparam int RR_ARB_REQ_NUM_DEFAULT  = 4;
    localparam int RR_ARB_MAX_HOLD_DEFAULT = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Hold counter width: enough to count 0..max_hold, never narrower than 1 bit
    // so the counter still exists when the timeout is disabled.
    function automatic int rr_hold_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_mask_select.sv
// Round-robin winner selection: lowest requester at or above the pointer,
// falling back to the lowest requester overall when none sit above it.
module rr_mask_select #(
    parameter int REQ_NUM = 4
) (
    input  logic [REQ_NUM-1:0]         i_req,
    input  logic [$clog2(REQ_NUM)-1:0] i_ptr,
    output logic [REQ_NUM-1:0]         o_winner_oh,
    output logic [$clog2(REQ_NUM)-1:0] o_winner_idx,
    output logic                       o_any_valid
);

    localparam int IDX_W = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0] w_mask;
    logic [REQ_NUM-1:0] w_masked;
    logic [REQ_NUM-1:0] w_masked_oh;
    logic [REQ_NUM-1:0] w_req_oh;

    // Clear every requester below the pointer; x & (-x) isolates the lowest set bit.
    assign w_mask      = ~((REQ_NUM'(1) << i_ptr) - REQ_NUM'(1));
    assign w_masked    = i_req & w_mask;
    assign w_masked_oh = w_masked & (~w_masked + REQ_NUM'(1));
    assign w_req_oh    = i_req & (~i_req + REQ_NUM'(1));
    assign o_winner_oh = (|w_masked) ? w_masked_oh : w_req_oh;
    assign o_any_valid = |i_req;

    // Encode the one-hot winner by OR-ing the index of each set bit.
    always_comb begin
        o_winner_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (o_winner_oh[i]) begin
                o_winner_idx = o_winner_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin lock arbiter: one requester owns the shared unit until it
// releases, drops its request, or exhausts the hold limit.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ARB_IDLE  | no owner; pick a winner from req relative to ptr
//   ARB_GRANT | owner holds the resource; watch release/req/hold limit
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int REQ_NUM  = RR_ARB_REQ_NUM_DEFAULT,
    parameter int MAX_HOLD = RR_ARB_MAX_HOLD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_NUM-1:0]         req,
    input  logic [REQ_NUM-1:0]         release_req,
    output logic [REQ_NUM-1:0]         grant,
    output logic [$clog2(REQ_NUM)-1:0] grant_id,
    output logic                       grant_valid,
    output logic                       timeout
);

    localparam int IDX_W  = $clog2(REQ_NUM);
    localparam int HOLD_W = rr_hold_width(MAX_HOLD);
    localparam bit HOLD_EN = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [REQ_NUM-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_id;
    logic               r_timeout;

    logic [REQ_NUM-1:0] w_win_oh;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any_req;
    logic               w_owner_done;
    logic               w_hold_limit;

    rr_mask_select #(
        .REQ_NUM (REQ_NUM)
    ) u_mask_select (
        .i_req        (req),
        .i_ptr        (r_ptr),
        .o_winner_oh  (w_win_oh),
        .o_winner_idx (w_win_idx),
        .o_any_valid  (w_any_req)
    );

    // Release wins over the hold limit, so a release on the last allowed
    // cycle ends the grant without a timeout pulse.
    assign w_owner_done = release_req[r_owner] | ~req[r_owner];
    assign w_hold_limit = HOLD_EN && (r_hold_cnt == HOLD_LAST);

    // Arbitration FSM with registered grant, owner index and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ARB_GRANT;
                        r_owner    <= w_win_idx;
                        r_grant    <= w_win_oh;
                        r_grant_id <= w_win_idx;
                        r_hold_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (w_owner_done || w_hold_limit) begin
                        // Rotate priority past the outgoing owner; wraps for free
                        // because REQ_NUM is a power of two.
                        r_state    <= ARB_IDLE;
                        r_ptr      <= r_owner + 1'b1;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_hold_cnt <= '0;
                        r_timeout  <= ~w_owner_done;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ARB_IDLE;
                    r_grant    <= '0;
                    r_grant_id <= '0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = |r_grant;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: the driver advances a behavioural
// model each edge and queues the expected outputs; the monitor pops and
// compares on the falling edge.
module tb_rr_lock_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  release_req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          timeout;

    rr_lock_arbiter #(
        .REQ_NUM  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_req (release_req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [IW-1:0] id;
        logic          v;
        logic          t;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: owner is -1 when nobody holds the resource,
    // held counts cycles the current grant has been visible.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    function automatic void model_step();
        int w;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_tmo   = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else begin
            if (release_req[m_owner] || !req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_tmo   = 1'b0;
            end else if (MH != 0 && m_held == MH) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.g  = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.id = (m_owner >= 0) ? IW'(m_owner) : '0;
        e.v  = (m_owner >= 0);
        e.t  = m_tmo;
        return e;
    endfunction

    task automatic cycle(input logic r, input logic [N-1:0] q, input logic [N-1:0] rl);
        @(negedge clk);
        rst         = r;
        req         = q;
        release_req = rl;
        @(posedge clk);
        cyc++;
        model_step();
        sb_q.push_back(model_out());
    endtask

    // Monitor: compare every registered output set against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v || timeout !== e.t) begin
                n_fail++;
                $display("FAIL out@cyc%0d: got grant=%b id=%0d valid=%b timeout=%b, want grant=%b id=%0d valid=%b timeout=%b",
                         cyc, grant, grant_id, grant_valid, timeout, e.g, e.id, e.v, e.t);
            end
        end
    end

    initial begin
        logic [N-1:0] q;
        logic [N-1:0] rl;
        rst = 1'b1;
        req = '0;
        release_req = '0;

        // Reset, then idle with no requests.
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        repeat (5) cycle(1'b0, 4'b0000, 4'b0000);

        // 1010 from ptr=0 -> owner 1; release -> ptr=2 -> owner 3.
        cycle(1'b0, 4'b1010, 4'b0000);
        cycle(1'b0, 4'b1010, 4'b0000);
        cycle(1'b0, 4'b1010, 4'b0010);
        cycle(1'b0, 4'b1010, 4'b0000);
        cycle(1'b0, 4'b1010, 4'b0000);
        cycle(1'b0, 4'b1010, 4'b1000);
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // All requesting, each owner releases after 3 granted cycles: 0,1,2,3,0.
        for (int i = 0; i < 21; i++) begin
            rl = (m_owner >= 0 && m_held >= 3) ? N'(1) << m_owner : '0;
            cycle(1'b0, 4'b1111, rl);
        end
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Requester 2 alone, never releasing: 16-cycle grant, timeout, re-grant.
        repeat (40) cycle(1'b0, 4'b0100, 4'b0000);
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Owner 1: non-owner release ignored, then release on the hold-limit cycle.
        cycle(1'b0, 4'b0010, 4'b0000);
        cycle(1'b0, 4'b0010, 4'b0100);
        cycle(1'b0, 4'b0010, 4'b0100);
        for (int i = 0; i < 40; i++) begin
            if (m_owner == 1 && m_held < MH) cycle(1'b0, 4'b0010, 4'b0000);
        end
        cycle(1'b0, 4'b0010, 4'b0010);
        repeat (3) cycle(1'b0, 4'b0000, 4'b0000);

        // Reset during a grant to requester 3, then 1001 -> requester 0.
        repeat (3) cycle(1'b0, 4'b1000, 4'b0000);
        cycle(1'b1, 4'b1000, 4'b0000);
        repeat (3) cycle(1'b0, 4'b1001, 4'b0000);
        repeat (2) cycle(1'b0, 4'b0000, 4'b0000);

        // Randomised traffic: sticky request levels, sporadic releases and resets.
        q = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) q[b] = ~q[b];
            end
            rl = ($urandom_range(5) == 0) ? N'($urandom) : '0;
            cycle(($urandom_range(199) == 0) ? 1'b1 : 1'b0, q, rl);
        end

        // Let the monitor drain, bounded to a few cycles.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
